shift_seq: RTL and testbench
============================

# shift_seq

Multi-cycle shifter for the LEGv8 datapath, covering LSL/LSR/ASR/ROR by a run-time amount. It is the variable-amount, bidirectional counterpart to the fixed left-shift on the branch-offset path. It shifts one bit position per clock under a start/done handshake, with a low-area loop in place of a 64-bit barrel shifter. It sits beside the ALU in the execute stage; the control unit stalls the pipeline while `busy` is high.

## Interface
- `N`, 64, data width (power of two, ≥ 8)
- `SW`, $clog2(N) (6), shift-amount width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  request; accepted only when `busy` = 0
- `op`  in  2  `shift_op_t`: LSL=00, LSR=01, ASR=10, ROR=11; sampled with `start`
- `a`  in  N  operand; sampled with `start`
- `shamt`  in  SW  shift amount 0..N-1; sampled with `start`
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle
- `done`  out  1  one-cycle pulse; `y` is valid in this cycle
- `y`  out  N  result register; holds its value until the next `done`
- `zero`  out  1  `y` == 0, registered with `y`

## Operation
- FSM states (local enum): IDLE, SHIFT, FIN.
- IDLE:
  - `busy` = 0, `done` = 0.
  - If `start`: `acc` <= `a`, `cnt` <= `shamt`, `op_r` <= `op`; next state SHIFT.
- SHIFT:
  - `busy` = 1.
  - If `cnt` != 0: `acc` <= one-bit step of `acc` per `op_r`, `cnt` <= `cnt` - 1.
  - If `cnt` == 0: `y` <= `acc`, `zero` <= (`acc` == 0); next state FIN.
- FIN:
  - `busy` = 1, `done` = 1.
  - Next state IDLE unconditionally.
- One-bit step rules:
  - LSL: {acc[N-2:0], 0}
  - LSR: {0, acc[N-1:1]}
  - ASR: {acc[N-1], acc[N-1:1]}
  - ROR: {acc[0], acc[N-1:1]}
- `shamt` = 0 still passes through SHIFT once; `y` = `a`.
- `start` while `busy` = 1 is ignored. No queueing, and in-flight `op_r`/`cnt` are unaffected.
- `start` in the FIN cycle is ignored. The requester re-asserts it in IDLE.
- Input changes after acceptance have no effect on the result.
- Reset:
  - State = IDLE; `acc`, `cnt`, `op_r`, `y` = 0; `zero` = 1; `busy` = 0; `done` = 0.
  - A reset mid-operation aborts the operation; no `done` is produced for it.
  - Reset has priority over `start` in the same cycle.

## Timing
- `start` is sampled at edge E0. `busy` rises after E0.
- Shifts occur at edges E1..E`shamt`. `y` loads at edge E(`shamt`+1).
- `done` is high for exactly one cycle, after edge E(`shamt`+1); IDLE follows the next edge.
- Accept-to-`done` latency = `shamt` + 2 cycles. Minimum 2 (`shamt` = 0), maximum N+1 = 65.
- Back-to-back throughput: one operation per `shamt` + 3 cycles, because the earliest next acceptance is in the IDLE cycle after FIN.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.

## Structure
- `shift_pkg` holds:
  - `typedef enum logic [1:0] shift_op_t` {LSL, LSR, ASR, ROR}
  - Data-width constant `N_DEF` = 64
- The FSM state enum stays local to `shift_seq`.
- One sub-module: `shift_step`, a combinational one-bit shifter with parameter N, inputs `a`/`op`, output `y`. It is unit-testable in isolation.
- Estimated size: ~150 lines of RTL including `shift_step`.

## Test plan
- Reset, then idle:
  - Expect `busy` = 0, `done` = 0, `y` = 0, `zero` = 1.
  - Assert reset during a SHIFT with `shamt` = 40: state returns to IDLE, no `done` pulse, `y` = 0.
- LSR, `a` = 0xF000_0000_0000_0000, `shamt` = 4:
  - `done` arrives exactly 6 cycles after acceptance with `y` = 0x0F00_0000_0000_0000, `zero` = 0.
  - `busy` is high for 6 cycles.
- ASR, `a` = 0x8000_0000_0000_0001, `shamt` = 63:
  - `y` = 0xFFFF_FFFF_FFFF_FFFF after 65 cycles.
- Same operand, LSR `shamt` = 63:
  - `y` = 1.
- LSL, `a` = 1, `shamt` = 0:
  - `done` after 2 cycles, `y` = 1.
- LSL, `a` = 1, `shamt` = 63, then LSL by 1 on `a` = 0x8000_0000_0000_0000:
  - First: `y` = 0x8000_0000_0000_0000.
  - Second: `y` = 0, `zero` = 1.
- ROR, `a` = 0x0000_0000_0000_00A5, `shamt` = 8:
  - `y` = 0xA500_0000_0000_0000.
- Busy protocol:
  - Pulse `start` with a different `a`/`shamt` mid-SHIFT and again in the FIN cycle. Both are ignored; the first result is unchanged.
  - A `start` held continuously is accepted in each IDLE cycle, giving a period of `shamt` + 3.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared shift-op encoding and default data width for the shifter
package shift_pkg;
  typedef enum logic [1:0] {LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11} shift_op_t;
  localparam int N_DEF = 64;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational one-bit LSL/LSR/ASR/ROR step
// ports: a (operand), op (shift_op_t), y (a shifted by one position)
module shift_step
  import shift_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] a,
  input  shift_op_t    op,
  output logic [N-1:0] y
);
  always_comb y = op == LSL ? {a[N-2:0], 1'b0}
                            : {op == ASR ? a[N-1] : op == ROR ? a[0] : 1'b0, a[N-1:1]};
endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shifter, one bit position per clock under a start/done handshake
// ports: clk, reset (sync, active-high); start/op/a/shamt request (taken only when idle);
//        busy (accept+1 through done), done (1-cycle pulse), y (held result), zero (y == 0)
module shift_seq
  import shift_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  shift_op_t     op,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  y,
  output logic          zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t        state;
  logic [N-1:0]  acc;
  logic [N-1:0]  step;
  logic [SW-1:0] cnt;
  shift_op_t     op_r;
  shift_step #(.N(N)) u_step (.a(acc), .op(op_r), .y(step));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_r  <= LSL;
      y     <= '0;
      zero  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= a;
          cnt   <= shamt;
          op_r  <= op;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (cnt != '0) begin
          acc <= step;
          cnt <= cnt - 1'b1;
        end else begin
          y     <= acc;
          zero  <= acc == '0;
          done  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: scoreboard bench for shift_seq
module tb_shift_seq;
  import shift_pkg::*;
  typedef struct {
    logic [63:0] y;
    logic [63:0] z;
    int          c;
    int          sh;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  shift_op_t   op = LSL;
  logic [63:0] a = '0;
  logic [5:0]  shamt = '0;
  logic        busy, done, zero;
  logic [63:0] y;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          n_done = 0;
  int          n_push = 0;
  int          busy_n = 0;
  exp_t        q[$];
  exp_t        e;
  shift_seq #(.N(64)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .shamt(shamt),
    .busy(busy), .done(done), .y(y), .zero(zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(shift_op_t o, logic [63:0] v, int s);
    case (o)
      LSL:     return v << s;
      LSR:     return v >> s;
      ASR:     return 64'($signed(v) >>> s);
      default: return s == 0 ? v : (v >> s) | (v << (64 - s));
    endcase
  endfunction
  task automatic push_exp(shift_op_t o, logic [63:0] v, int s);
    exp_t x;
    x.y  = model(o, v, s);
    x.z  = {63'd0, x.y == 64'd0};
    x.c  = cyc;
    x.sh = s;
    q.push_back(x);
    n_push++;
  endtask
  task automatic issue(shift_op_t o, logic [63:0] v, int s, bit push = 1'b1);
    @(negedge clk);
    op = o;
    a = v;
    shamt = 6'(s);
    start = 1'b1;
    if (push) push_exp(o, v, s);
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom};
    shamt = 6'($urandom);
    op = shift_op_t'($urandom_range(0, 3));
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (reset) busy_n = 0;
    else begin
      if (busy) busy_n++;
      if (done) begin
        n_done++;
        if (q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("y", y, e.y);
          chk("zero", {63'd0, zero}, e.z);
          chk("latency", 64'(cyc - e.c), 64'(e.sh + 2));
          chk("busy_len", 64'(busy_n), 64'(e.sh + 2));
        end
        busy_n = 0;
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_y", y, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd1);
    issue(LSL, 64'hFFFF_FFFF_FFFF_FFFF, 40, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_y", y, 64'd0);
    chk("abort_zero", {63'd0, zero}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    issue(LSR, 64'hF000_0000_0000_0000, 4);  drain();
    issue(ASR, 64'h8000_0000_0000_0001, 63); drain();
    issue(LSR, 64'h8000_0000_0000_0001, 63); drain();
    issue(LSL, 64'd1, 0);                    drain();
    issue(LSL, 64'd1, 63);                   drain();
    issue(LSL, 64'h8000_0000_0000_0000, 1);  drain();
    issue(ROR, 64'h0000_0000_0000_00A5, 8);  drain();
    for (int i = 0; i < 6; i++) begin
      issue(shift_op_t'($urandom_range(0, 3)), {$urandom, $urandom}, int'($urandom_range(0, 63)));
      drain();
    end
    issue(ASR, 64'h9234_5678_9ABC_DEF0, 10);
    repeat (3) @(negedge clk);
    op = LSL; a = 64'h1; shamt = 6'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    op = ROR; a = 64'h55; shamt = 6'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    chk("ignored_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    op = ROR; a = 64'hDEAD_BEEF_0123_4567; shamt = 6'd5; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(ROR, 64'hDEAD_BEEF_0123_4567, 5);
      if (i < 2) repeat (8) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("done_count", 64'(n_done), 64'(n_push));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
